// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the multi-cycle sequencer:
//   - one-hot state encodings FETCH..HALT and the bit index of each state
//   - MIN_STATE_W, the smallest legal one-hot register width
//   - seq_state_e, a decoded view of the raw one-hot register, and the
//     decode_state() helper that produces it (ST_ILLEGAL for any value that is
//     not exactly one of the six legal encodings)
// -----------------------------------------------------------------------------
package seq_pkg;

    localparam int MIN_STATE_W = 6;

    localparam int FETCH_BIT     = 0;
    localparam int DECODE_BIT    = 1;
    localparam int ALU_BIT       = 2;
    localparam int MEM_BIT       = 3;
    localparam int REG_WRITE_BIT = 4;
    localparam int HALT_BIT      = 5;

    localparam logic [MIN_STATE_W-1:0] FETCH     = 6'h01;
    localparam logic [MIN_STATE_W-1:0] DECODE    = 6'h02;
    localparam logic [MIN_STATE_W-1:0] ALU       = 6'h04;
    localparam logic [MIN_STATE_W-1:0] MEM       = 6'h08;
    localparam logic [MIN_STATE_W-1:0] REG_WRITE = 6'h10;
    localparam logic [MIN_STATE_W-1:0] HALT      = 6'h20;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_ALU,
        ST_MEM,
        ST_REG_WRITE,
        ST_HALT,
        ST_ILLEGAL
    } seq_state_e;

    // low: the six defined state bits; upper_set: any bit above them is 1.
    function automatic seq_state_e decode_state(input logic [MIN_STATE_W-1:0] low,
                                                input logic                   upper_set);
        seq_state_e kind;
        kind = ST_ILLEGAL;
        if (!upper_set) begin
            case (low)
                FETCH:     kind = ST_FETCH;
                DECODE:    kind = ST_DECODE;
                ALU:       kind = ST_ALU;
                MEM:       kind = ST_MEM;
                REG_WRITE: kind = ST_REG_WRITE;
                HALT:      kind = ST_HALT;
                default:   kind = ST_ILLEGAL;
            endcase
        end
        return kind;
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// -----------------------------------------------------------------------------
// seq_wait_timer
// Counts consecutive stall cycles and raises a sticky flag once the run of
// stalls reaches WAIT_TIMEOUT. With WAIT_TIMEOUT = 0 the check is disabled and
// the flag is tied low.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset; clears count and flag
//   count_en     in   this cycle is a stall that counts (need_wait in a
//                     non-HALT state); any other cycle restarts the run
//   wait_timeout out  sticky stuck-wait flag, cleared only by rst
// -----------------------------------------------------------------------------
module seq_wait_timer #(
    parameter int WAIT_TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    output logic wait_timeout
);

    generate
        if (WAIT_TIMEOUT == 0) begin : g_disabled
            assign wait_timeout = 1'b0;

            // Inputs are intentionally unused in this configuration.
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, count_en};
        end else begin : g_enabled
            localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);

            logic [CNT_W-1:0] wait_cnt;

            // NOTE: sequential state is updated with non-blocking assignments so
            // every flop samples pre-edge values regardless of block ordering.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wait_cnt     <= '0;
                    wait_timeout <= 1'b0;
                end else if (!count_en) begin
                    wait_cnt <= '0;
                end else if (wait_cnt != CNT_W'(WAIT_TIMEOUT)) begin
                    // Saturate at WAIT_TIMEOUT so a long stall cannot wrap the
                    // counter; the flag is set on the edge the count gets there.
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (wait_cnt == CNT_W'(WAIT_TIMEOUT - 1)) begin
                        wait_timeout <= 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
// One-hot multi-cycle control sequencer: FETCH -> DECODE -> ALU -> [MEM] ->
// [REG_WRITE], with stall, halt at instruction boundaries, a retired
// instruction counter and a stuck-wait detector.
//
// Parameters:
//   STATE_W      one-hot register width (>= 6); bits above HALT stay 0
//   RETIRE_CNT_W retired-instruction counter width (wraps)
//   WAIT_TIMEOUT consecutive stall cycles before wait_timeout; 0 disables
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   need_wait                stall: hold the current (non-HALT) state
//   uses_mem, uses_wb        instruction needs MEM / REG_WRITE; sampled in DECODE
//   halt_req                 enter HALT at the next instruction end; hold HALT
//   step_mode, step_req      single-step control (SEQ_SINGLE_STEP_EN only)
//   fetch_en .. reg_write_en stage enables = state bits 0..4
//   incr_pc                  PC increment strobe, once per instruction
//   instr_retired            combinational pulse in the last cycle of an instr
//   retired_cnt              retired-instruction count
//   halted                   state is HALT
//   wait_timeout             sticky stuck-wait flag
//   dbg_state                raw state register
//
// Build option: define SEQ_SINGLE_STEP_EN to add the step_mode/step_req ports.
// Without it the sequencer behaves as if step_mode were tied to 0.
// -----------------------------------------------------------------------------
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int STATE_W      = 10,
    parameter int RETIRE_CNT_W = 16,
    parameter int WAIT_TIMEOUT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    need_wait,
    input  logic                    uses_mem,
    input  logic                    uses_wb,
    input  logic                    halt_req,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                    step_mode,
    input  logic                    step_req,
`endif
    output logic                    fetch_en,
    output logic                    decode_en,
    output logic                    alu_en,
    output logic                    mem_en,
    output logic                    reg_write_en,
    output logic                    incr_pc,
    output logic                    instr_retired,
    output logic [RETIRE_CNT_W-1:0] retired_cnt,
    output logic                    halted,
    output logic                    wait_timeout,
    output logic [STATE_W-1:0]      dbg_state
);

    typedef logic [STATE_W-1:0] state_t;

    state_t     state;
    state_t     state_next;
    seq_state_e cur;

    logic mem_flag, mem_flag_next;
    logic wb_flag,  wb_flag_next;
    logic end_instr;
    logic halt_at_end;
    logic leave_halt;
    logic step_mode_i;
    logic step_req_i;

`ifdef SEQ_SINGLE_STEP_EN
    assign step_mode_i = step_mode;
    assign step_req_i  = step_req;
`else
    assign step_mode_i = 1'b0;
    assign step_req_i  = 1'b0;
`endif

    // Shifting out the defined bits leaves only the bits that must be zero;
    // this works for any STATE_W >= MIN_STATE_W without a zero-width slice.
    assign cur = decode_state(state[MIN_STATE_W-1:0], |(state >> MIN_STATE_W));

    // In single-step mode every instruction stops in HALT; halt_req always
    // wins over a step request so the core can be parked reliably.
    assign halt_at_end = halt_req | step_mode_i;
    assign leave_halt  = !halt_req && (!step_mode_i || step_req_i);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned and infers a latch.
        state_next    = state;
        mem_flag_next = mem_flag;
        wb_flag_next  = wb_flag;
        end_instr     = 1'b0;

        case (cur)
            ST_FETCH: begin
                if (!need_wait) state_next = state_t'(DECODE);
            end
            ST_DECODE: begin
                if (!need_wait) begin
                    state_next    = state_t'(ALU);
                    mem_flag_next = uses_mem;
                    wb_flag_next  = uses_wb;
                end
            end
            ST_ALU: begin
                if (!need_wait) begin
                    if (mem_flag)     state_next = state_t'(MEM);
                    else if (wb_flag) state_next = state_t'(REG_WRITE);
                    else              end_instr  = 1'b1;
                end
            end
            ST_MEM: begin
                if (!need_wait) begin
                    if (wb_flag) state_next = state_t'(REG_WRITE);
                    else         end_instr  = 1'b1;
                end
            end
            ST_REG_WRITE: begin
                if (!need_wait) end_instr = 1'b1;
            end
            ST_HALT: begin
                // Stalls do not apply while halted.
                if (leave_halt) state_next = state_t'(FETCH);
            end
            default: begin
                // Corrupted one-hot value: restart cleanly, nothing retires.
                state_next = state_t'(FETCH);
            end
        endcase

        if (end_instr) begin
            state_next = halt_at_end ? state_t'(HALT) : state_t'(FETCH);
        end
    end

    // ------------------------------------------------------------------------
    // State, latched decode flags and retire counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= state_t'(FETCH);
            mem_flag    <= 1'b0;
            wb_flag     <= 1'b0;
            retired_cnt <= '0;
        end else begin
            state    <= state_next;
            mem_flag <= mem_flag_next;
            wb_flag  <= wb_flag_next;
            if (end_instr) begin
                retired_cnt <= retired_cnt + RETIRE_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stuck-wait detection
    // ------------------------------------------------------------------------
    seq_wait_timer #(
        .WAIT_TIMEOUT (WAIT_TIMEOUT)
    ) u_wait_timer (
        .clk          (clk),
        .rst          (rst),
        .count_en     (need_wait && (cur != ST_HALT)),
        .wait_timeout (wait_timeout)
    );

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign fetch_en      = state[FETCH_BIT];
    assign decode_en     = state[DECODE_BIT];
    assign alu_en        = state[ALU_BIT];
    assign mem_en        = state[MEM_BIT];
    assign reg_write_en  = state[REG_WRITE_BIT];
    // Only the cycle DECODE is left gives the strobe, so stalls never repeat it.
    assign incr_pc       = (cur == ST_DECODE) && !need_wait;
    assign instr_retired = end_instr;
    assign halted        = (cur == ST_HALT);
    assign dbg_state     = state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
// Directed scenarios with literal expectations followed by a randomized run.
// A per-instruction reference model (queue of remaining stages) predicts every
// output each cycle; a compare process checks the DUT against it on the
// falling edge. Inputs change 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;

    localparam int ST_W = 10;
    localparam int CW   = 4;
    localparam int WT   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic need_wait = 1'b0;
    logic uses_mem = 1'b0;
    logic uses_wb = 1'b0;
    logic halt_req = 1'b0;
    logic step_mode = 1'b0;
    logic step_req = 1'b0;

    logic            fetch_en, decode_en, alu_en, mem_en, reg_write_en;
    logic            incr_pc, instr_retired, halted, wait_timeout;
    logic [CW-1:0]   retired_cnt;
    logic [ST_W-1:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(
        .STATE_W      (ST_W),
        .RETIRE_CNT_W (CW),
        .WAIT_TIMEOUT (WT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .need_wait     (need_wait),
        .uses_mem      (uses_mem),
        .uses_wb       (uses_wb),
        .halt_req      (halt_req),
`ifdef SEQ_SINGLE_STEP_EN
        .step_mode     (step_mode),
        .step_req      (step_req),
`endif
        .fetch_en      (fetch_en),
        .decode_en     (decode_en),
        .alu_en        (alu_en),
        .mem_en        (mem_en),
        .reg_write_en  (reg_write_en),
        .incr_pc       (incr_pc),
        .instr_retired (instr_retired),
        .retired_cnt   (retired_cnt),
        .halted        (halted),
        .wait_timeout  (wait_timeout),
        .dbg_state     (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: the current instruction is a queue of the stage codes
    // still to visit; the front is the current stage.
    // ------------------------------------------------------------------------
    int m_stages[$];
    bit m_valid   = 1'b0;
    bit m_halted  = 1'b0;
    bit m_illegal = 1'b0;
    int m_illegal_val = 0;
    int m_cnt  = 0;
    int m_wait = 0;
    bit m_wto  = 1'b0;

    function automatic bit m_at_end();
        return !m_illegal && !m_halted && m_stages.size() == 1 && m_stages[0] >= 4;
    endfunction

    task automatic model_step();
        bit exit_halt;
        if (rst) begin
            m_valid   = 1'b1;
            m_halted  = 1'b0;
            m_illegal = 1'b0;
            m_stages  = '{1, 2};
            m_cnt     = 0;
            m_wait    = 0;
            m_wto     = 1'b0;
        end else if (m_valid) begin
            if (need_wait && !m_halted) begin
                m_wait++;
                if (WT > 0 && m_wait >= WT) m_wto = 1'b1;
            end else begin
                m_wait = 0;
            end
            exit_halt = !halt_req && (!step_mode || step_req);
            if (m_illegal) begin
                m_illegal = 1'b0;
                m_stages  = '{1, 2};
            end else if (m_halted) begin
                if (exit_halt) begin
                    m_halted = 1'b0;
                    m_stages = '{1, 2};
                end
            end else if (!need_wait) begin
                if (m_at_end()) begin
                    m_cnt = (m_cnt + 1) % (1 << CW);
                    if (halt_req || step_mode) m_halted = 1'b1;
                    else                       m_stages = '{1, 2};
                end else if (m_stages[0] == 2) begin
                    m_stages = '{4};
                    if (uses_mem) m_stages.push_back(8);
                    if (uses_wb)  m_stages.push_back(16);
                end else begin
                    void'(m_stages.pop_front());
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    function automatic logic [22:0] model_outputs();
        logic [ST_W-1:0] st;
        logic inc, ret, hlt;
        if (m_illegal)     st = ST_W'(m_illegal_val);
        else if (m_halted) st = ST_W'(32);
        else               st = ST_W'(m_stages[0]);
        hlt = !m_illegal && m_halted;
        inc = !m_illegal && !m_halted && m_stages[0] == 2 && !need_wait;
        ret = m_at_end() && !need_wait;
        return {st, st[0], st[1], st[2], st[3], st[4], inc, ret, hlt, m_wto, CW'(m_cnt)};
    endfunction

    function automatic logic [22:0] dut_outputs();
        return {dbg_state, fetch_en, decode_en, alu_en, mem_en, reg_write_en,
                incr_pc, instr_retired, halted, wait_timeout, retired_cnt};
    endfunction

    always @(negedge clk) begin
        if (m_valid) check("model_cmp", 32'(dut_outputs()), 32'(model_outputs()));
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        neg();
        check("rst_state", dbg_state, 32'h001);
        check("rst_fetch_en", fetch_en, 1);
        check("rst_cnt", retired_cnt, 0);
        check("rst_others", {decode_en, alu_en, mem_en, reg_write_en,
                             incr_pc, instr_retired, halted, wait_timeout}, 0);

        // ALU-only instruction: 01,02,04,01
        tick(); neg();
        check("alu_decode", dbg_state, 32'h002);
        check("alu_incr", incr_pc, 1);
        tick(); neg();
        check("alu_alu", dbg_state, 32'h004);
        check("alu_retire", {instr_retired, incr_pc}, 2'b10);
        tick(); neg();
        check("alu_back", dbg_state, 32'h001);
        check("alu_cnt", retired_cnt, 1);

        // MEM + WB instruction: 01,02,04,08,10,01
        uses_mem = 1'b1; uses_wb = 1'b1;
        tick(); neg(); check("mw_decode", dbg_state, 32'h002);
        tick(); neg(); check("mw_alu", {dbg_state, instr_retired}, {10'h004, 1'b0});
        tick(); neg(); check("mw_mem", {dbg_state, mem_en}, {10'h008, 1'b1});
        tick(); neg();
        check("mw_regw", {dbg_state, reg_write_en, instr_retired}, {10'h010, 2'b11});
        check("mw_cnt_before", retired_cnt, 1);
        tick(); uses_mem = 1'b0; uses_wb = 1'b0;
        neg();
        check("mw_back", dbg_state, 32'h001);
        check("mw_cnt_after", retired_cnt, 2);

        // 3 stall cycles in DECODE
        tick(); need_wait = 1'b1;
        neg(); check("stall1", {dbg_state, incr_pc}, {10'h002, 1'b0});
        repeat (2) tick();
        neg(); check("stall3", {dbg_state, incr_pc}, {10'h002, 1'b0});
        tick(); need_wait = 1'b0;
        neg(); check("stall_release", {dbg_state, incr_pc}, {10'h002, 1'b1});
        tick(); tick(); neg();
        check("stall_done", {dbg_state, retired_cnt}, {10'h001, 4'd3});

        // Halt at ALU end, need_wait ignored in HALT
        tick(); tick(); halt_req = 1'b1;
        neg(); check("halt_retire", instr_retired, 1);
        tick(); need_wait = 1'b1;
        neg();
        check("halt_state", {dbg_state, halted}, {10'h020, 1'b1});
        check("halt_enables", {fetch_en, decode_en, alu_en, mem_en, reg_write_en}, 0);
        tick(); neg(); check("halt_hold", dbg_state, 32'h020);
        halt_req = 1'b0; need_wait = 1'b0;
        tick(); neg(); check("halt_exit", {dbg_state, halted}, {10'h001, 1'b0});

        // halt_req only in FETCH does not halt later
        halt_req = 1'b1;
        tick(); halt_req = 1'b0;
        tick(); tick(); neg();
        check("early_halt_req", {dbg_state, retired_cnt}, {10'h001, 4'd5});

        // Wait timeout in MEM
        uses_mem = 1'b1;
        tick(); tick(); tick(); need_wait = 1'b1;
        neg(); check("wto_start", {dbg_state, wait_timeout}, {10'h008, 1'b0});
        repeat (3) tick();
        neg(); check("wto_3", wait_timeout, 0);
        tick(); neg(); check("wto_4", {dbg_state, wait_timeout}, {10'h008, 1'b1});
        need_wait = 1'b0; uses_mem = 1'b0;
        tick(); neg();
        check("wto_sticky", {dbg_state, wait_timeout, retired_cnt}, {10'h001, 1'b1, 4'd6});

        rst = 1'b1; tick(); rst = 1'b0;
        neg(); check("wto_rst", {dbg_state, wait_timeout, retired_cnt}, {10'h001, 1'b0, 4'd0});

        // Counter wrap
        repeat (15) repeat (3) tick();
        neg(); check("cnt_15", retired_cnt, 15);
        repeat (3) tick();
        neg(); check("cnt_wrap", {dbg_state, retired_cnt}, {10'h001, 4'd0});

        // Illegal state deposit
        #1;
        dut.state = 10'h006;
        m_illegal_val = 6;
        m_illegal = 1'b1;
        #1;
        check("illegal_seen", {dbg_state, instr_retired, halted}, {10'h006, 2'b00});
        tick(); neg();
        check("illegal_recover", {dbg_state, retired_cnt}, {10'h001, 4'd0});

        // Reset while halted
        halt_req = 1'b1;
        repeat (3) tick();
        neg(); check("halt_before_rst", dbg_state, 32'h020);
        rst = 1'b1; tick(); rst = 1'b0; halt_req = 1'b0;
        neg(); check("rst_in_halt", {dbg_state, halted, retired_cnt}, {10'h001, 1'b0, 4'd0});

`ifdef SEQ_SINGLE_STEP_EN
        step_mode = 1'b1;
        repeat (3) tick();
        neg(); check("step_halt", {dbg_state, halted}, {10'h020, 1'b1});
        tick(); neg(); check("step_hold", dbg_state, 32'h020);
        step_req = 1'b1; tick(); step_req = 1'b0;
        neg(); check("step_go", dbg_state, 32'h001);
        repeat (3) tick();
        neg(); check("step_one", {dbg_state, retired_cnt}, {10'h020, 4'd2});
        halt_req = 1'b1; step_req = 1'b1;
        tick(); neg(); check("step_halt_wins", dbg_state, 32'h020);
        halt_req = 1'b0; step_req = 1'b0; step_mode = 1'b0;
        tick(); neg(); check("step_off", dbg_state, 32'h001);
`endif

        // Randomized run; the compare process checks every cycle.
        for (int i = 0; i < 2000; i++) begin
            tick();
            rst       = ($urandom_range(0, 63) == 0);
            need_wait = ($urandom_range(0, 3) == 0);
            uses_mem  = $urandom_range(0, 1) == 1;
            uses_wb   = $urandom_range(0, 1) == 1;
            halt_req  = ($urandom_range(0, 7) == 0);
`ifdef SEQ_SINGLE_STEP_EN
            step_mode = ($urandom_range(0, 7) == 0) ? ~step_mode : step_mode;
            step_req  = ($urandom_range(0, 3) == 0);
`endif
        end
        neg();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Parametrised successor to the core's fixed FETCH→DECODE→ALU control unit.
- One-hot multi-cycle sequencer that also drives MEM and REG_WRITE stages per instruction, supports halt, counts retired instructions and flags stuck wait conditions.
- Sits between the datapath stage enables and the memory/bus wait logic.

Parameters:
- STATE_W, 10, one-hot state width; must be ≥ 6; upper bits unused and held 0.
- RETIRE_CNT_W, 16, width of the retired-instruction counter.
- WAIT_TIMEOUT, 0, consecutive need_wait cycles before wait_timeout is set; 0 disables the check.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- need_wait  in  1  stall: hold the current state.
- uses_mem  in  1  decoded instruction needs MEM stage; sampled in DECODE.
- uses_wb  in  1  decoded instruction needs REG_WRITE stage; sampled in DECODE.
- halt_req  in  1  stop at the next instruction boundary.
- fetch_en, decode_en, alu_en, mem_en, reg_write_en  out  1 each  stage enables (state bits 0..4).
- incr_pc  out  1  PC increment strobe.
- instr_retired  out  1  one-cycle pulse on instruction completion.
- retired_cnt  out  RETIRE_CNT_W  retired-instruction count.
- halted  out  1  state is HALT.
- wait_timeout  out  1  sticky stuck-wait flag.
- dbg_state  out  STATE_W  raw state register.

Behaviour:
- State encodings (one-hot): FETCH=0x01, DECODE=0x02, ALU=0x04, MEM=0x08, REG_WRITE=0x10, HALT=0x20.
- Reset (rst=1 at edge):
  - state=FETCH; retired_cnt=0; wait_timeout=0; wait counter=0; latched mem/wb flags=0.
  - Hence fetch_en=1, all other stage enables, incr_pc, instr_retired and halted are 0.
  - Reset has priority over everything, including mid-instruction and during HALT.
- Stall: in any state other than HALT, need_wait=1 holds the state unchanged.
- Transitions with need_wait=0:
  - FETCH → DECODE.
  - DECODE → ALU; latch uses_mem and uses_wb.
  - ALU → MEM if mem; else REG_WRITE if wb; else end.
  - MEM → REG_WRITE if wb; else end.
  - REG_WRITE → end.
- "End" of an instruction:
  - instr_retired=1 that cycle (combinational); retired_cnt+1 at the edge, modulo 2^RETIRE_CNT_W.
  - Next state is HALT if halt_req=1, else FETCH.
- HALT:
  - need_wait ignored; halted=1; all stage enables 0.
  - → FETCH on the edge where halt_req=0.
- halt_req outside an instruction end has no effect until that end.
- incr_pc = DECODE & !need_wait: exactly one pulse per instruction, even across stalls.
- Latency: minimum 3 cycles/instruction; uses_mem+uses_wb gives 5; each stall cycle adds 1.
- Wait timer (WAIT_TIMEOUT>0):
  - Counts consecutive cycles with need_wait=1 in a non-HALT state.
  - Cleared by any cycle with need_wait=0.
  - When the count reaches WAIT_TIMEOUT, wait_timeout←1 and stays 1 until rst.
  - The sequencer keeps stalling normally.
- Illegal state (not exactly one valid bit set): next state is FETCH; no retire; no counter change.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds inputs step_mode (1) and step_req (1).
  - While step_mode=1, every instruction end goes to HALT.
  - HALT exits to FETCH for one instruction on a cycle with step_req=1, even if step_mode is still 1.
  - halt_req=1 overrides step_req and holds HALT.
- When undefined:
  - Ports absent.
  - Behaviour identical to step_mode=0.

Decomposition:
- Package seq_pkg holds:
  - State localparams FETCH..HALT and the bit indices of each state.
  - The minimum STATE_W constant (6).
- Sub-module seq_wait_timer:
  - Holds the consecutive-wait counter and the sticky flag.
  - Parameter WAIT_TIMEOUT; counter width $clog2(WAIT_TIMEOUT+1).
  - Tied off when WAIT_TIMEOUT=0.

Test Plan:
- rst=1 for 2 cycles, then instr with uses_mem=0, uses_wb=0 → dbg_state 0x01,0x02,0x04,0x01; incr_pc high only in the DECODE cycle; instr_retired pulses in the ALU cycle; retired_cnt=1.
- uses_mem=1, uses_wb=1 → 0x01,0x02,0x04,0x08,0x10,0x01 (5 cycles); one incr_pc pulse; retired_cnt increments at the REG_WRITE→FETCH edge.
- need_wait=1 for 3 cycles in DECODE → state held at 0x02 for 4 cycles; incr_pc asserted only in the final (need_wait=0) cycle.
- halt_req=1 raised during ALU of an ALU-only instr → next state 0x20, halted=1; drop halt_req → FETCH next edge; halt_req raised in FETCH has no effect until that instruction's end.
- WAIT_TIMEOUT=4, need_wait held 4 cycles in MEM → wait_timeout=1 after 4th edge, stays 1 after need_wait drops; rst clears it. Also RETIRE_CNT_W=4: 16 retires → retired_cnt wraps to 0.
- Force dbg_state to 0x06 via testbench deposit → next state 0x01, no retire. With SEQ_SINGLE_STEP_EN, step_mode=1 → HALT after each instr; one step_req pulse → exactly one instruction runs.
